// File: rtl/arrow_shot_ctrl_if.sv
// Arrow controller bus: frame/fire/collision inputs and arrow position/visibility outputs.
// The controller connects to the slave modport; the stimulus side uses master.
interface arrow_shot_ctrl_if;
  logic        startOfFrame;
  logic        fireKey;
  logic [10:0] charX;
  logic        arrowHitTop;
  logic        arrowHitBubble;
  logic [10:0] arrowX;
  logic [10:0] arrowTopY;
  logic        arrowActive;
  logic        bubblePop;

  modport master (
    output startOfFrame, fireKey, charX, arrowHitTop, arrowHitBubble,
    input  arrowX, arrowTopY, arrowActive, bubblePop
  );

  modport slave (
    input  startOfFrame, fireKey, charX, arrowHitTop, arrowHitBubble,
    output arrowX, arrowTopY, arrowActive, bubblePop
  );
endinterface

// File: rtl/arrow_shot_ctrl.sv
// Arrow flight controller: latches per-pixel collision pulses during the scan and
// steps the fire/fly/cooldown FSM once per frame on startOfFrame.
module arrow_shot_ctrl #(
  parameter int ARROW_SPEED     = 4,
  parameter int Y_START         = 400,
  parameter int X_OFFSET        = 16,
  parameter int COOLDOWN_FRAMES = 8
) (
  input  logic              clk,
  input  logic              resetN,
  arrow_shot_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, FLYING, COOLDOWN} state_e;

  localparam logic [10:0] YS  = 11'(Y_START);
  localparam logic [10:0] SPD = 11'(ARROW_SPEED);
  localparam logic [10:0] XO  = 11'(X_OFFSET);
  localparam int          CW  = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES) : 1;
  localparam logic [CW-1:0] CD_LAST = CW'(COOLDOWN_FRAMES - 1);

  state_e        state_q;
  logic [10:0]   arrowX_q, arrowTopY_q;
  logic          arrowActive_q, bubblePop_q;
  logic          fireReq_q, firePrev_q;
  logic          hitTopL_q, hitBubL_q;
  logic [CW-1:0] cdCnt_q;

  logic fireEdge, hitTop, hitBub;

  assign fireEdge = bus.fireKey & ~firePrev_q;
  // A pulse landing on the startOfFrame cycle still belongs to the closing frame.
  assign hitTop   = hitTopL_q | bus.arrowHitTop;
  assign hitBub   = hitBubL_q | bus.arrowHitBubble;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q       <= IDLE;
      arrowX_q      <= '0;
      arrowTopY_q   <= YS;
      arrowActive_q <= 1'b0;
      bubblePop_q   <= 1'b0;
      fireReq_q     <= 1'b0;
      firePrev_q    <= 1'b0;
      hitTopL_q     <= 1'b0;
      hitBubL_q     <= 1'b0;
      cdCnt_q       <= '0;
    end else begin
      firePrev_q  <= bus.fireKey;
      bubblePop_q <= 1'b0;

      if (state_q == FLYING) begin
        if (bus.arrowHitTop)    hitTopL_q <= 1'b1;
        if (bus.arrowHitBubble) hitBubL_q <= 1'b1;
      end
      if (state_q == IDLE && fireEdge) fireReq_q <= 1'b1;

      if (bus.startOfFrame) begin
        hitTopL_q <= 1'b0;
        hitBubL_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (fireReq_q) begin
              state_q       <= FLYING;
              arrowActive_q <= 1'b1;
              arrowX_q      <= bus.charX + XO;
              arrowTopY_q   <= YS;
              fireReq_q     <= 1'b0;
            end
          end
          FLYING: begin
            if (hitBub || hitTop || arrowTopY_q == '0) begin
              state_q       <= COOLDOWN;
              arrowActive_q <= 1'b0;
              bubblePop_q   <= hitBub;
              arrowTopY_q   <= YS;
              cdCnt_q       <= '0;
            end else begin
              // Saturate rather than wrap when the tip is closer than one step to row 0.
              arrowTopY_q <= (arrowTopY_q >= SPD) ? arrowTopY_q - SPD : '0;
            end
          end
          COOLDOWN: begin
            if (cdCnt_q == CD_LAST) begin
              state_q <= IDLE;
              cdCnt_q <= '0;
            end else begin
              cdCnt_q <= cdCnt_q + CW'(1);
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.arrowX      = arrowX_q;
  assign bus.arrowTopY   = arrowTopY_q;
  assign bus.arrowActive = arrowActive_q;
  assign bus.bubblePop   = bubblePop_q;

endmodule

// File: tb/tb_arrow_shot_ctrl.sv
// Bench for arrow_shot_ctrl: per-frame expectations are queued as frames are driven
// and drained by a monitor on each startOfFrame; a second instance runs ARROW_SPEED=7.
module tb_arrow_shot_ctrl;
  logic clk = 1'b0;
  logic resetN = 1'b1;
  always #5 clk = ~clk;

  arrow_shot_ctrl_if bus ();
  arrow_shot_ctrl_if bus7 ();

  arrow_shot_ctrl dut (.clk(clk), .resetN(resetN), .bus(bus.slave));
  arrow_shot_ctrl #(.ARROW_SPEED(7)) dut7 (.clk(clk), .resetN(resetN), .bus(bus7.slave));

  int vectors = 0;
  int errors  = 0;
  logic [23:0] exp_q[$];

  function automatic logic [23:0] st(input logic a, input logic p, input int x, input int y);
    return {a, p, 11'(x), 11'(y)};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic sof(input logic [23:0] e);
    exp_q.push_back(e);
    cyc(2);
    bus.startOfFrame = 1'b1;
    cyc(1);
    bus.startOfFrame = 1'b0;
  endtask

  task automatic sof7();
    cyc(2);
    bus7.startOfFrame = 1'b1;
    cyc(1);
    bus7.startOfFrame = 1'b0;
  endtask

  task automatic sb_monitor();
    logic [23:0] got, e;
    forever begin
      @(posedge clk);
      if (bus.startOfFrame === 1'b1) begin
        #1;
        got = {bus.arrowActive, bus.bubblePop, bus.arrowX, bus.arrowTopY};
        vectors++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sof_unexpected got=%h", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL sof_frame got act=%0b pop=%0b x=%0d y=%0d want act=%0b pop=%0b x=%0d y=%0d",
                     got[23], got[22], got[21:11], got[10:0], e[23], e[22], e[21:11], e[10:0]);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    #1;
    vectors++;
    if ({bus.arrowActive, bus.bubblePop, bus.arrowX, bus.arrowTopY} !== st(0, 0, 0, 400)) begin
      errors++;
      $display("FAIL reset_state got act=%0b pop=%0b x=%0d y=%0d want 0 0 0 400",
               bus.arrowActive, bus.bubblePop, bus.arrowX, bus.arrowTopY);
    end
    cyc(2);
    resetN = 1'b1;
    cyc(1);
  endtask

  task automatic test_fire_flight();
    bus.charX = 11'd100;
    sof(st(0, 0, 0, 400));
    bus.fireKey = 1'b1;
    cyc(2);
    vectors++;
    if (bus.arrowActive !== 1'b0) begin
      errors++;
      $display("FAIL fire_before_sof got=%0b want=0", bus.arrowActive);
    end
    sof(st(1, 0, 116, 400));
    bus.charX = 11'd300;
    sof(st(1, 0, 116, 396));
    sof(st(1, 0, 116, 392));
    bus.fireKey = 1'b0;
  endtask

  task automatic test_bubble_hit();
    cyc(1);
    bus.arrowHitBubble = 1'b1;
    cyc(1);
    bus.arrowHitBubble = 1'b0;
    sof(st(0, 1, 116, 400));
    vectors++;
    if (bus.bubblePop !== 1'b1) begin
      errors++;
      $display("FAIL bubble_pop_pulse got=%0b want=1", bus.bubblePop);
    end
    cyc(1);
    vectors++;
    if (bus.bubblePop !== 1'b0) begin
      errors++;
      $display("FAIL bubble_pop_width got=%0b want=0", bus.bubblePop);
    end
    for (int f = 1; f <= 8; f++) begin
      sof(st(0, 0, 116, 400));
      if (f == 5) begin
        bus.fireKey = 1'b1;
        cyc(2);
        bus.fireKey = 1'b0;
      end
    end
    sof(st(0, 0, 116, 400));
    bus.fireKey = 1'b1;
    cyc(1);
    bus.fireKey = 1'b0;
    sof(st(1, 0, 316, 400));
  endtask

  task automatic test_both_hits();
    cyc(1);
    bus.arrowHitTop = 1'b1;
    cyc(1);
    bus.arrowHitTop = 1'b0;
    cyc(1);
    bus.arrowHitBubble = 1'b1;
    cyc(1);
    bus.arrowHitBubble = 1'b0;
    sof(st(0, 1, 316, 400));
    for (int f = 1; f <= 8; f++) sof(st(0, 0, 316, 400));
  endtask

  task automatic test_coincident();
    bus.fireKey = 1'b1;
    cyc(1);
    bus.fireKey = 1'b0;
    sof(st(1, 0, 316, 400));
    sof(st(1, 0, 316, 396));
    exp_q.push_back(st(0, 0, 316, 400));
    cyc(2);
    bus.arrowHitTop = 1'b1;
    bus.startOfFrame = 1'b1;
    cyc(1);
    bus.arrowHitTop = 1'b0;
    bus.startOfFrame = 1'b0;
    for (int f = 1; f <= 8; f++) begin
      sof(st(0, 0, 316, 400));
      if (f == 2) begin
        bus.arrowHitBubble = 1'b1;
        cyc(1);
        bus.arrowHitBubble = 1'b0;
      end
    end
    bus.fireKey = 1'b1;
    cyc(1);
    bus.fireKey = 1'b0;
    sof(st(1, 0, 316, 400));
    sof(st(1, 0, 316, 396));
  endtask

  task automatic test_hold_key();
    bus.fireKey = 1'b1;
    cyc(1);
    bus.arrowHitTop = 1'b1;
    cyc(1);
    bus.arrowHitTop = 1'b0;
    sof(st(0, 0, 316, 400));
    for (int f = 1; f <= 8; f++) sof(st(0, 0, 316, 400));
    for (int f = 0; f < 3; f++) sof(st(0, 0, 316, 400));
    bus.fireKey = 1'b0;
    cyc(1);
    bus.fireKey = 1'b1;
    cyc(1);
    sof(st(1, 0, 316, 400));
    bus.fireKey = 1'b0;
    bus.arrowHitBubble = 1'b1;
    cyc(1);
    bus.arrowHitBubble = 1'b0;
    sof(st(0, 1, 316, 400));
    for (int f = 1; f <= 8; f++) sof(st(0, 0, 316, 400));
  endtask

  task automatic test_saturate_and_reset();
    logic [23:0] got, want;
    bus7.charX = 11'd50;
    bus7.fireKey = 1'b1;
    cyc(1);
    bus7.fireKey = 1'b0;
    for (int k = 0; k <= 59; k++) begin
      sof7();
      if (k <= 57)      want = st(1, 0, 66, 400 - 7 * k);
      else if (k == 58) want = st(1, 0, 66, 0);
      else              want = st(0, 0, 66, 400);
      got = {bus7.arrowActive, bus7.bubblePop, bus7.arrowX, bus7.arrowTopY};
      vectors++;
      if (got !== want) begin
        errors++;
        $display("FAIL saturate_frame%0d got act=%0b pop=%0b x=%0d y=%0d want act=%0b pop=%0b x=%0d y=%0d",
                 k, got[23], got[22], got[21:11], got[10:0], want[23], want[22], want[21:11], want[10:0]);
      end
    end
    for (int f = 1; f <= 8; f++) sof7();
    bus7.fireKey = 1'b1;
    cyc(1);
    bus7.fireKey = 1'b0;
    sof7();
    sof7();
    vectors++;
    if ({bus7.arrowActive, bus7.arrowTopY} !== {1'b1, 11'd393}) begin
      errors++;
      $display("FAIL reflight got act=%0b y=%0d want act=1 y=393", bus7.arrowActive, bus7.arrowTopY);
    end
    bus.fireKey = 1'b1;
    cyc(1);
    #2;
    resetN = 1'b0;
    #1;
    vectors++;
    if ({bus7.arrowActive, bus7.bubblePop, bus7.arrowX, bus7.arrowTopY} !== st(0, 0, 0, 400)) begin
      errors++;
      $display("FAIL async_reset got act=%0b pop=%0b x=%0d y=%0d want 0 0 0 400",
               bus7.arrowActive, bus7.bubblePop, bus7.arrowX, bus7.arrowTopY);
    end
    bus.fireKey = 1'b0;
    cyc(2);
    resetN = 1'b1;
    cyc(1);
    sof(st(0, 0, 0, 400));
    sof7();
    vectors++;
    if (bus7.arrowActive !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle got=%0b want=0", bus7.arrowActive);
    end
  endtask

  initial begin
    bus.startOfFrame = 1'b0;  bus.fireKey = 1'b0;  bus.charX = '0;
    bus.arrowHitTop = 1'b0;   bus.arrowHitBubble = 1'b0;
    bus7.startOfFrame = 1'b0; bus7.fireKey = 1'b0; bus7.charX = '0;
    bus7.arrowHitTop = 1'b0;  bus7.arrowHitBubble = 1'b0;
    fork
      sb_monitor();
    join_none
    #2;
    test_reset();
    test_fire_flight();
    test_bubble_hit();
    test_both_hits();
    test_coincident();
    test_hold_key();
    test_saturate_and_reset();
    cyc(2);
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending want=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
